mem_stage_dcache: RTL and testbench

- Memory-stage data-cache block; sits directly downstream of the EX/MEM pipeline register and consumes its MemRead, MemWrite, ALU_Out (address) and dataRt (store data) outputs.
- Direct-mapped, write-through, write-allocate cache.
- On a miss it fills an 8-word block from main memory and raises `stall`, which the pipeline uses to hold the EX/MEM register (`wen = ~stall`).

---
 rtl/mem_stage_dcache.sv | 213 +++++++++++++++++++++
 tb/tb_mem_stage_dcache.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_dcache.sv
// -----------------------------------------------------------------------------
// mem_stage_dcache
//
// Memory-stage data cache. It sits directly after the EX/MEM pipeline register.
// It is direct-mapped, write-through and write-allocate. Each line holds eight
// 16-bit words.
//
// On a miss the block raises stall and fetches the whole 8-word block from main
// memory. It issues eight consecutive read requests, and the responses may
// overlap the issue phase. The access that is still held is then re-evaluated
// in IDLE. It hits on that cycle, so a pending store writes through then.
//
// Optional build macro: DCACHE_STATS_EN
//   defined   : saturating 16-bit hit_cnt / miss_cnt counters
//   undefined : hit_cnt / miss_cnt tied to zero, no counter flops
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous reset, active HIGH despite the name
//   MemRead    load request from EX/MEM
//   MemWrite   store request from EX/MEM (wins when both are set)
//   addr       byte address
//   wdata      store data
//   rdata      load data (combinational on a read hit, else 0)
//   stall      pipeline hold request
//   mem_en     main-memory request strobe
//   mem_wr     1 = write request, 0 = read request
//   mem_addr   main-memory byte address
//   mem_wdata  main-memory write data
//   mem_rdata  main-memory read data
//   mem_rvalid mem_rdata valid, responses arrive in request order
//   hit_cnt    hit counter (0 unless DCACHE_STATS_EN)
//   miss_cnt   miss counter (0 unless DCACHE_STATS_EN)
// -----------------------------------------------------------------------------
module mem_stage_dcache #(
   parameter int SETS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        stall,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic [15:0] hit_cnt,
   output logic [15:0] miss_cnt
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 12 - IDX_W;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] FILL = 1'b1;

   // Storage. Word arrays are addressed as {line, word offset}.
   logic [15:0]      data_q [SETS*8];
   logic [TAG_W-1:0] tag_q  [SETS];
   logic [SETS-1:0]  valid_q;

   logic [0:0]  state_q,     state_d;
   logic [3:0]  issue_cnt_q, issue_cnt_d;   // bit 3 set = all 8 requests issued
   logic [2:0]  recv_cnt_q,  recv_cnt_d;
   logic [11:0] base_q,      base_d;        // block address addr[15:4] of the miss

   // Address decode of the incoming access
   logic [2:0]       off;
   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic             access;
   logic             hit;

   assign off    = addr[3:1];
   assign idx    = addr[3+IDX_W:4];
   assign tag    = addr[15:4+IDX_W];
   assign access = MemRead | MemWrite;
   assign hit    = access & valid_q[idx] & (tag_q[idx] == tag);

   // The line being filled comes from the latched block address, so the fill
   // does not depend on the pipeline holding addr stable.
   logic [IDX_W-1:0] fill_idx;
   logic [TAG_W-1:0] fill_tag;
   assign fill_idx = base_q[IDX_W-1:0];
   assign fill_tag = base_q[11:IDX_W];

   logic idle_wr_hit;
   logic fill_rx;
   logic fill_done;
   assign idle_wr_hit = (state_q == IDLE) & hit & MemWrite;
   assign fill_rx     = (state_q == FILL) & mem_rvalid;
   assign fill_done   = fill_rx & (recv_cnt_q == 3'd7);

   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      recv_cnt_d  = recv_cnt_q;
      base_d      = base_q;
      rdata       = 16'h0000;
      stall       = 1'b0;
      mem_en      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = 16'h0000;
      mem_wdata   = 16'h0000;

      if (state_q == IDLE) begin
         if (access) begin
            if (hit) begin
               if (MemWrite) begin
                  mem_en    = 1'b1;
                  mem_wr    = 1'b1;
                  mem_addr  = addr;
                  mem_wdata = wdata;
               end else begin
                  rdata = data_q[{idx, off}];
               end
            end else begin
               stall       = 1'b1;
               state_d     = FILL;
               issue_cnt_d = 4'd0;
               recv_cnt_d  = 3'd0;
               base_d      = addr[15:4];
            end
         end
      end else begin
         stall = 1'b1;
         if (!issue_cnt_q[3]) begin
            mem_en      = 1'b1;
            // The low 4 bits of the base are zero, so base + 2*n is a concatenation.
            mem_addr    = {base_q, issue_cnt_q[2:0], 1'b0};
            issue_cnt_d = issue_cnt_q + 4'd1;
         end
         if (mem_rvalid) begin
            recv_cnt_d = recv_cnt_q + 3'd1;
            if (recv_cnt_q == 3'd7) begin
               state_d = IDLE;
            end
         end
      end

      // All outputs are quiet while reset is held.
      if (rst_n) begin
         rdata     = 16'h0000;
         stall     = 1'b0;
         mem_en    = 1'b0;
         mem_wr    = 1'b0;
         mem_addr  = 16'h0000;
         mem_wdata = 16'h0000;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q     <= IDLE;
         issue_cnt_q <= 4'd0;
         recv_cnt_q  <= 3'd0;
         base_q      <= 12'h000;
         valid_q     <= '0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         recv_cnt_q  <= recv_cnt_d;
         base_q      <= base_d;
         if (fill_done) begin
            valid_q[fill_idx] <= 1'b1;
         end
      end
   end

   // Data and tag arrays are never cleared. Only the valid bits gate a hit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         if (idle_wr_hit) begin
            data_q[{idx, off}] <= wdata;
         end else if (fill_rx) begin
            data_q[{fill_idx, recv_cnt_q}] <= mem_rdata;
         end
         if (fill_done) begin
            tag_q[fill_idx] <= fill_tag;
         end
      end
   end

`ifdef DCACHE_STATS_EN
   logic [15:0] hit_cnt_q;
   logic [15:0] miss_cnt_q;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         hit_cnt_q  <= 16'h0000;
         miss_cnt_q <= 16'h0000;
      end else if ((state_q == IDLE) && access) begin
         if (hit) begin
            if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
         end else begin
            if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
         end
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`else
   assign hit_cnt  = 16'h0000;
   assign miss_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_stage_dcache.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_dcache
//
// Directed bench for mem_stage_dcache.
//
// The stimulus pushes the expected results into queues:
//   exp_rd   - read-hit data
//   exp_wr   - write-through address and data
//   exp_fill - fill request addresses
//
// A monitor pops exp_rd and exp_wr when the DUT presents them. The memory model
// pops exp_fill on each read request. The memory answers with a fixed latency
// of 4 cycles.
// -----------------------------------------------------------------------------
module tb_mem_stage_dcache;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MemRead;
   logic        MemWrite;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        stall;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_rvalid;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   bit mon_en  = 1'b1;

   logic [15:0] exp_rd   [$];
   logic [31:0] exp_wr   [$];
   logic [15:0] exp_fill [$];

   typedef struct {
      int          due;
      logic [15:0] data;
   } resp_t;
   resp_t       pend [$];
   logic [15:0] mem  [logic [15:0]];

   mem_stage_dcache #(.SETS(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .stall      (stall),
      .mem_en     (mem_en),
      .mem_wr     (mem_wr),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid),
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Unwritten memory: word k of block 0x0040 is A000+k, and the pattern
   // continues linearly with the word address.
   function automatic logic [15:0] mem_read(input logic [15:0] a);
      logic [15:0] v;
      if (mem.exists(a)) v = mem[a];
      else               v = 16'hA000 + ((a - 16'h0040) >> 1);
      return v;
   endfunction

   // Memory model. A read sampled in cycle c answers with rvalid in cycle c+LAT.
   always @(negedge clk) begin
      resp_t r;
      logic [15:0] ef;
      cyc++;
      mem_rvalid = 1'b0;
      mem_rdata  = 16'h0000;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         r = pend.pop_front();
         mem_rvalid = 1'b1;
         mem_rdata  = r.data;
      end
      if (mem_en && !rst_n) begin
         if (mem_wr) begin
            mem[mem_addr] = mem_wdata;
         end else begin
            pend.push_back('{cyc + LAT, mem_read(mem_addr)});
            if (exp_fill.size() == 0) begin
               check("unexpected_fill_req", {16'h0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
               ef = exp_fill.pop_front();
               check("fill_addr", {16'h0, mem_addr}, {16'h0, ef});
            end
         end
      end
   end

   // Monitor: read-hit data and write-through traffic.
   always @(negedge clk) begin
      logic [15:0] er;
      logic [31:0] ew;
      if (!rst_n && mon_en) begin
         if (MemRead && !MemWrite && !stall) begin
            if (exp_rd.size() == 0) begin
               check("unexpected_rd_hit", {16'h0, rdata}, 32'hFFFF_FFFF);
            end else begin
               er = exp_rd.pop_front();
               check("rd_data", {16'h0, rdata}, {16'h0, er});
               check("rd_hit_mem_en", {31'h0, mem_en}, 32'h0);
            end
         end
         if (mem_en && mem_wr) begin
            if (exp_wr.size() == 0) begin
               check("unexpected_wr_thru", {mem_addr, mem_wdata}, 32'hFFFF_FFFF);
            end else begin
               ew = exp_wr.pop_front();
               check("wr_thru", {mem_addr, mem_wdata}, ew);
            end
         end
      end
   end

   task automatic push_fill(input logic [15:0] base, input int n);
      for (int i = 0; i < n; i++) exp_fill.push_back(base + 16'(2 * i));
   endtask

   // One access: hold it until the first cycle with stall low, and check how
   // many stall cycles it took.
   task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input int exp_stall, input string nm);
      int  n;
      bit  done;
      n    = 0;
      done = 1'b0;
      @(posedge clk); #1;
      MemRead = rd; MemWrite = wr; addr = a; wdata = d;
      while (!done) begin
         @(negedge clk);
         if (!stall) done = 1'b1;
         else begin
            n++;
            if (n > 200) begin
               check({nm, "_timeout"}, n, exp_stall);
               done = 1'b1;
            end
         end
      end
      if (n <= 200) check({nm, "_stall_cycles"}, n, exp_stall);
   endtask

   task automatic go_idle();
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0; addr = 16'h0; wdata = 16'h0;
   endtask

   task automatic check_stats(input string nm, input logic [15:0] h, input logic [15:0] m);
`ifdef DCACHE_STATS_EN
      check({nm, "_hit_cnt"},  {16'h0, hit_cnt},  {16'h0, h});
      check({nm, "_miss_cnt"}, {16'h0, miss_cnt}, {16'h0, m});
`else
      check({nm, "_hit_cnt"},  {16'h0, hit_cnt},  32'h0);
      check({nm, "_miss_cnt"}, {16'h0, miss_cnt}, 32'h0);
`endif
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset while a read is presented: the outputs must stay quiet.
      rst_n = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; addr = 16'h0046; wdata = 16'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stall",  {31'h0, stall},  32'h0);
      check("rst_mem_en", {31'h0, mem_en}, 32'h0);
      check("rst_rdata",  {16'h0, rdata},  32'h0);
      @(posedge clk); #1;
      rst_n = 1'b0; MemRead = 1'b0; addr = 16'h0;
      @(negedge clk);
      check("idle_stall",    {31'h0, stall},    32'h0);
      check("idle_mem_addr", {16'h0, mem_addr}, 32'h0);
      check("idle_rdata",    {16'h0, rdata},    32'h0);
      check_stats("post_rst", 16'd0, 16'd0);

      // Cold read miss: stall = 1 + 8 + LAT cycles.
      push_fill(16'h0040, 8);
      exp_rd.push_back(16'hA003);
      access(1'b1, 1'b0, 16'h0046, 16'h0, 13, "cold_rd");

      // Read hit
      exp_rd.push_back(16'hA007);
      access(1'b1, 1'b0, 16'h004E, 16'h0, 0, "rd_hit");

      // Write hit: write-through in the same cycle, then read back.
      exp_wr.push_back({16'h0042, 16'h1234});
      access(1'b0, 1'b1, 16'h0042, 16'h1234, 0, "wr_hit");
      exp_rd.push_back(16'h1234);
      access(1'b1, 1'b0, 16'h0042, 16'h0, 0, "rd_after_wr");

      // Write miss at the same index with another tag. The line is evicted and
      // the write-through follows the fill.
      push_fill(16'h0140, 8);
      exp_wr.push_back({16'h0140, 16'h5678});
      access(1'b0, 1'b1, 16'h0140, 16'h5678, 13, "wr_miss");
      exp_rd.push_back(16'h5678);
      access(1'b1, 1'b0, 16'h0140, 16'h0, 0, "rd_0140");
      exp_rd.push_back(16'hA081);
      access(1'b1, 1'b0, 16'h0142, 16'h0, 0, "rd_0142");

      // The evicted block misses again. The refill sees the earlier store.
      push_fill(16'h0040, 8);
      exp_rd.push_back(16'hA003);
      access(1'b1, 1'b0, 16'h0046, 16'h0, 13, "re_miss");
      exp_rd.push_back(16'h1234);
      access(1'b1, 1'b0, 16'h0042, 16'h0, 0, "rd_refilled");
      go_idle();
      @(negedge clk);
      check_stats("pre_rst", 16'd9, 16'd3);

      // Reset after 3 fill requests have been issued.
      push_fill(16'h0060, 3);
      @(posedge clk); #1;
      MemRead = 1'b1; addr = 16'h0060;
      @(negedge clk);
      check("midfill_miss_stall", {31'h0, stall}, 32'h1);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1; MemRead = 1'b0; addr = 16'h0;
      @(negedge clk);
      check("midfill_rst_mem_en", {31'h0, mem_en}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("post_midfill_stall",  {31'h0, stall},  32'h0);
      check("post_midfill_mem_en", {31'h0, mem_en}, 32'h0);
      check_stats("post_midfill", 16'd0, 16'd0);
      repeat (8) @(negedge clk);   // stray rvalids arrive here and are dropped
      check("strays_drained", pend.size(), 32'h0);

      // All valid bits were cleared, so this misses again.
      push_fill(16'h0040, 8);
      exp_rd.push_back(16'hA000);
      access(1'b1, 1'b0, 16'h0040, 16'h0, 13, "rd_after_rst");
      go_idle();
      @(negedge clk);
      check_stats("final", 16'd1, 16'd1);

`ifdef DCACHE_STATS_EN
      // Hold a read hit long enough to saturate the hit counter.
      mon_en = 1'b0;
      @(posedge clk); #1;
      MemRead = 1'b1; addr = 16'h0040;
      repeat (65540) @(posedge clk);
      @(negedge clk);
      check("hit_cnt_sat", {16'h0, hit_cnt}, 32'h0000_FFFF);
      repeat (2) @(negedge clk);
      check("hit_cnt_hold", {16'h0, hit_cnt}, 32'h0000_FFFF);
      check("miss_cnt_soak", {16'h0, miss_cnt}, 32'h0000_0001);
      go_idle();
      mon_en = 1'b1;
`endif

      repeat (2) @(negedge clk);
      check("exp_rd_left",   exp_rd.size(),   32'h0);
      check("exp_wr_left",   exp_wr.size(),   32'h0);
      check("exp_fill_left", exp_fill.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
